song_writer: RTL and testbench

- Records live key presses into the song RAM, using the same entry format the song reader consumes during playback.
- Sits beside the MCU. It takes one-pulsed key events and the 48 Hz beat, measures note and rest lengths in beats, and emits one RAM write per entry.
- Closes each recording with a terminator word so the song reader stops cleanly on playback.

---
 rtl/song_writer.sv | 217 +++++++++++++++++++++
 tb/tb_song_writer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_writer.sv
// song_writer
//   Records live key presses into the song RAM as playback-format entries.
//   Each entry is {advance=1, params[2:0], note[5:0], duration[5:0]}; a rest
//   is an entry with note=0. A recording always ends with 16'h0000 so the
//   song reader stops cleanly.
//
// Ports
//   clk, reset     : system clock, asynchronous active-high reset
//   beat           : one-cycle 48 Hz beat pulse
//   record_button  : one-pulsed, toggles recording
//   song           : target slot, sampled on record start
//   key_press      : one-cycle pulse, key went down (note/params sampled)
//   key_release    : one-cycle pulse, held key went up
//   key_note       : note number (nonzero)
//   key_params     : note parameters
//   mem_we/addr/wdata : registered RAM write port, addr = {song, index}
//   recording      : high while capturing
//   song_full      : sticky, last recording ran out of slots
//   entry_count    : content entries written in this/last recording
module song_writer #(
    parameter int IDX_WIDTH = 5,
    parameter int DUR_MAX   = 63
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat,
    input  logic                   record_button,
    input  logic [1:0]             song,
    input  logic                   key_press,
    input  logic                   key_release,
    input  logic [5:0]             key_note,
    input  logic [2:0]             key_params,
    output logic                   mem_we,
    output logic [IDX_WIDTH+1:0]   mem_addr,
    output logic [15:0]            mem_wdata,
    output logic                   recording,
    output logic                   song_full,
    output logic [IDX_WIDTH-1:0]   entry_count
);

    typedef enum logic [2:0] {IDLE, REST, HOLD, FLUSH, TERM} state_t;

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = '1;
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
    localparam logic [5:0]           DUR_SAT  = 6'(DUR_MAX);

    state_t                 state_q, state_d;
    logic [1:0]             song_q, song_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [5:0]             rest_q, rest_d;
    logic [5:0]             hold_q, hold_d;
    logic [5:0]             note_q, note_d;
    logic [2:0]             params_q, params_d;
    logic [IDX_WIDTH-1:0]   count_q, count_d;
    logic                   full_q, full_d;
    logic                   rec_q, rec_d;
    logic                   we_q, we_d;
    logic [IDX_WIDTH+1:0]   addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;

    logic [5:0]             rest_beat, hold_beat;
    logic [IDX_WIDTH-1:0]   idx_inc;
    logic                   idx_fills;

    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c >= DUR_SAT) ? DUR_SAT : c + 6'd1;
    endfunction

    // A note always lasts at least one beat, even if released before any beat.
    function automatic logic [5:0] note_dur(input logic [5:0] c);
        return (c == 6'd0) ? 6'd1 : c;
    endfunction

    // Counters including a beat that coincides with this cycle's key event.
    assign rest_beat = beat ? sat_inc(rest_q) : rest_q;
    assign hold_beat = beat ? sat_inc(hold_q) : hold_q;
    assign idx_inc   = idx_q + IDX_ONE;
    // The final slot is reserved for the terminator.
    assign idx_fills = (idx_inc == IDX_LAST);

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        idx_d    = idx_q;
        rest_d   = rest_q;
        hold_d   = hold_q;
        note_d   = note_q;
        params_d = params_q;
        count_d  = count_q;
        full_d   = full_q;
        rec_d    = rec_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE: begin
                if (record_button) begin
                    song_d  = song;
                    idx_d   = '0;
                    rest_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    rec_d   = 1'b1;
                    state_d = REST;
                end
            end

            REST: begin
                if (record_button) begin
                    state_d = TERM;
                end else begin
                    rest_d = rest_beat;
                    if (key_press) begin
                        note_d   = key_note;
                        params_d = key_params;
                        hold_d   = '0;
                        state_d  = HOLD;
                        if (rest_beat != 6'd0) begin
                            we_d    = 1'b1;
                            addr_d  = {song_q, idx_q};
                            wdata_d = {1'b1, 3'b000, 6'b000000, rest_beat};
                            idx_d   = idx_inc;
                            count_d = count_q + IDX_ONE;
                            // Rest took the last content slot: the note is dropped.
                            if (idx_fills) begin
                                full_d  = 1'b1;
                                state_d = TERM;
                            end
                        end
                    end
                end
            end

            HOLD: begin
                hold_d = hold_beat;
                if (record_button) begin
                    state_d = FLUSH;
                end else if (key_release) begin
                    we_d    = 1'b1;
                    addr_d  = {song_q, idx_q};
                    wdata_d = {1'b1, params_q, note_q, note_dur(hold_beat)};
                    idx_d   = idx_inc;
                    count_d = count_q + IDX_ONE;
                    rest_d  = '0;
                    state_d = REST;
                    if (idx_fills) begin
                        full_d  = 1'b1;
                        state_d = TERM;
                    end
                end
            end

            FLUSH: begin
                we_d    = 1'b1;
                addr_d  = {song_q, idx_q};
                wdata_d = {1'b1, params_q, note_q, note_dur(hold_q)};
                idx_d   = idx_inc;
                count_d = count_q + IDX_ONE;
                if (idx_fills) begin
                    full_d = 1'b1;
                end
                state_d = TERM;
            end

            TERM: begin
                we_d    = 1'b1;
                addr_d  = {song_q, idx_q};
                wdata_d = 16'h0000;
                rec_d   = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            song_q   <= '0;
            idx_q    <= '0;
            rest_q   <= '0;
            hold_q   <= '0;
            note_q   <= '0;
            params_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            rec_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            song_q   <= song_d;
            idx_q    <= idx_d;
            rest_q   <= rest_d;
            hold_q   <= hold_d;
            note_q   <= note_d;
            params_q <= params_d;
            count_q  <= count_d;
            full_q   <= full_d;
            rec_q    <= rec_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign recording   = rec_q;
    assign song_full   = full_q;
    assign entry_count = count_q;

endmodule

// File: tb/tb_song_writer.sv
// Testbench for song_writer: directed scenarios plus randomized key traffic,
// all checked against an event-level model of the recording rules.
module tb_song_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        beat = 1'b0;
    logic        record_button = 1'b0;
    logic [1:0]  song = 2'd0;
    logic        key_press = 1'b0;
    logic        key_release = 1'b0;
    logic [5:0]  key_note = 6'd0;
    logic [2:0]  key_params = 3'd0;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        recording;
    logic        song_full;
    logic [4:0]  entry_count;

    song_writer #(.IDX_WIDTH(5), .DUR_MAX(63)) dut (
        .clk(clk), .reset(reset), .beat(beat), .record_button(record_button),
        .song(song), .key_press(key_press), .key_release(key_release),
        .key_note(key_note), .key_params(key_params), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .recording(recording),
        .song_full(song_full), .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    // Event-level model: counts beats between key events as plain integers
    // and builds the list of RAM writes a recording should produce.
    bit         m_rec;
    bit         m_holding;
    bit         m_full;
    logic [1:0] m_song;
    logic [5:0] m_note;
    logic [2:0] m_par;
    int         m_beats;
    int         m_n;

    function automatic logic [5:0] clip(input int b, input bit is_note);
        int d;
        d = (b > 63) ? 63 : b;
        if (is_note && d == 0) d = 1;
        return 6'(d);
    endfunction

    task automatic m_term();
        exp_q.push_back(wr_t'({m_song, 5'(m_n), 16'h0000}));
        m_rec = 0;
        m_holding = 0;
    endtask

    task automatic m_emit(input logic [15:0] d);
        exp_q.push_back(wr_t'({m_song, 5'(m_n), d}));
        m_n++;
        if (m_n == 31) begin
            m_full = 1;
            m_term();
        end
    endtask

    task automatic model_step(input bit b, input bit pr, input bit rl, input bit rb,
                              input logic [1:0] sg, input logic [5:0] nt, input logic [2:0] pa);
        if (!m_rec) begin
            if (rb) begin
                m_rec = 1; m_song = sg; m_n = 0; m_full = 0;
                m_beats = 0; m_holding = 0;
            end
        end else if (rb) begin
            if (m_holding) m_emit({1'b1, m_par, m_note, clip(m_beats, 1)});
            if (m_rec) m_term();
        end else if (!m_holding) begin
            m_beats += int'(b);
            if (pr) begin
                if (m_beats > 0) m_emit({1'b1, 9'd0, clip(m_beats, 0)});
                if (m_rec) begin
                    m_holding = 1; m_note = nt; m_par = pa; m_beats = 0;
                end
            end
        end else begin
            m_beats += int'(b);
            if (rl) begin
                m_emit({1'b1, m_par, m_note, clip(m_beats, 1)});
                m_holding = 0;
                m_beats = 0;
            end
        end
    endtask

    // Apply one clock cycle of inputs (record is never combined with a beat).
    task automatic cycle(input bit b, input bit pr, input bit rl, input bit rb,
                         input logic [1:0] sg, input logic [5:0] nt, input logic [2:0] pa);
        beat = b; key_press = pr; key_release = rl; record_button = rb;
        song = sg; key_note = nt; key_params = pa;
        model_step(b, pr, rl, rb, sg, nt, pa);
        @(posedge clk);
        #1;
        beat = 0; key_press = 0; key_release = 0; record_button = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 2'd0, 6'd0, 3'd0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 2'd0, 6'd0, 3'd0);
    endtask

    task automatic rec(input logic [1:0] sg);
        cycle(0, 0, 0, 1, sg, 6'd0, 3'd0);
    endtask

    task automatic press(input logic [5:0] nt, input logic [2:0] pa);
        cycle(0, 1, 0, 0, 2'd0, nt, pa);
    endtask

    task automatic release_key();
        cycle(0, 0, 1, 0, 2'd0, 6'd0, 3'd0);
    endtask

    task automatic end_check(input string tag);
        idle(3);
        check({tag, "_count"}, 32'(entry_count), 32'(m_n));
        check({tag, "_full"}, 32'(song_full), 32'(m_full));
        check({tag, "_recording"}, 32'(recording), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_recording"}, 32'(recording), 32'd0);
        check({tag, "_full"}, 32'(song_full), 32'd0);
        check({tag, "_count"}, 32'(entry_count), 32'd0);
    endtask

    // Write monitor: every observed write must be the next expected one.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            $display("[TB] write addr=%02h data=%04h", mem_addr, mem_wdata);
            obs_q.push_back(wr_t'({mem_addr, mem_wdata}));
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e.addr));
                check("write_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    initial begin
        m_rec = 0; m_holding = 0; m_full = 0; m_n = 0; m_beats = 0;
        m_song = 0; m_note = 0; m_par = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 0;
        idle(2);

        // Basic note: song 2, note 10, params 3, 5 beats
        obs_q.delete();
        rec(2'd2); press(6'd10, 3'd3); beats(5); release_key(); rec(2'd0);
        end_check("tp1");
        check("tp1_nwrites", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            check("tp1_data0", 32'(obs_q[0].data), 32'hB285);
            check("tp1_addr0", 32'(obs_q[0].addr), 32'h40);
            check("tp1_data1", 32'(obs_q[1].data), 32'h0000);
            check("tp1_addr1", 32'(obs_q[1].addr), 32'h41);
        end

        // Leading rest then note
        obs_q.delete();
        rec(2'd1); beats(3); press(6'd20, 3'd0); beats(2); release_key(); rec(2'd0);
        end_check("tp2");
        check("tp2_nwrites", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() >= 3) begin
            check("tp2_rest", 32'(obs_q[0].data), 32'h8003);
            check("tp2_note", 32'(obs_q[1].data), 32'h8502);
            check("tp2_term_addr", 32'(obs_q[2].addr), 32'h22);
        end

        // Minimum duration and saturation
        obs_q.delete();
        rec(2'd0); press(6'd5, 3'd1); release_key();
        press(6'd6, 3'd2); beats(70); release_key(); rec(2'd0);
        end_check("tp3");
        if (obs_q.size() >= 2) begin
            check("tp3_min_dur", 32'(obs_q[0].data[5:0]), 32'd1);
            check("tp3_sat_dur", 32'(obs_q[1].data[5:0]), 32'd63);
        end

        // Coincident beats on release and press
        obs_q.delete();
        rec(2'd3); press(6'd7, 3'd4); beats(4);
        cycle(1, 0, 1, 0, 2'd0, 6'd0, 3'd0);
        cycle(1, 1, 0, 0, 2'd0, 6'd9, 3'd0);
        release_key(); rec(2'd0);
        end_check("tp4");
        if (obs_q.size() >= 2) begin
            check("tp4_release_beat", 32'(obs_q[0].data[5:0]), 32'd5);
            check("tp4_press_beat", 32'(obs_q[1].data), 32'h8001);
        end

        // Capacity: 31 one-beat notes
        obs_q.delete();
        rec(2'd3);
        for (int i = 0; i < 31; i++) begin
            press(6'(i + 1), 3'(i));
            beats(1);
            release_key();
        end
        idle(3);
        press(6'd1, 3'd0); beats(1); release_key(); press(6'd2, 3'd0);
        end_check("tp5");
        check("tp5_full", 32'(song_full), 32'd1);
        check("tp5_nwrites", 32'(obs_q.size()), 32'd32);
        if (obs_q.size() >= 32) begin
            check("tp5_term_addr", 32'(obs_q[31].addr), 32'h7F);
            check("tp5_term_data", 32'(obs_q[31].data), 32'h0000);
        end

        // Reset mid-HOLD aborts without a terminator
        obs_q.delete();
        rec(2'd2); press(6'd11, 3'd2); beats(2);
        #2 reset = 1;
        #1;
        check_outputs_zero("midreset");
        m_rec = 0; m_holding = 0; m_n = 0; m_full = 0;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 0;
        idle(3);
        check("midreset_nowrite", 32'(obs_q.size()), 32'd0);
        rec(2'd1); beats(1); press(6'd3, 3'd0); release_key(); rec(2'd0);
        end_check("tp6");
        if (obs_q.size() >= 1) begin
            check("tp6_first_addr", 32'(obs_q[0].addr), 32'h20);
            check("tp6_first_data", 32'(obs_q[0].data), 32'h8001);
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit b, pr, rl;
            if (!m_rec) begin
                idle(3);
                rec(2'($urandom));
            end else if ($urandom_range(0, 99) < 2) begin
                rec(2'd0);
            end else begin
                b  = ($urandom_range(0, 2) == 0);
                pr = m_holding ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 5) == 0);
                rl = m_holding ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
                cycle(b, pr, rl, 0, 2'd0, 6'($urandom_range(1, 63)), 3'($urandom));
            end
        end
        if (m_rec) rec(2'd0);
        end_check("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
